// File: rtl/qoa_pkg.sv
// Shared QOA constants: slice geometry and the 16x4 dequantization magnitude table.
package qoa_pkg;

    localparam int SLICE_W       = 64;
    localparam int RES_PER_SLICE = 20;
    localparam int SF_W          = 4;
    localparam int QR_W          = 3;
    localparam int RES_BITS      = RES_PER_SLICE * QR_W;
    localparam int MAG_W         = 14;
    localparam int DQ_W          = 15;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Magnitude per scalefactor row; qr>>1 picks the column, qr[0] picks the sign.
    localparam logic [MAG_W-1:0] DEQUANT_MAG [16][4] = '{
        '{14'd1,    14'd3,    14'd5,    14'd7    },
        '{14'd5,    14'd18,   14'd32,   14'd49   },
        '{14'd16,   14'd53,   14'd95,   14'd147  },
        '{14'd34,   14'd113,  14'd203,  14'd315  },
        '{14'd63,   14'd210,  14'd378,  14'd588  },
        '{14'd104,  14'd345,  14'd621,  14'd966  },
        '{14'd158,  14'd528,  14'd950,  14'd1477 },
        '{14'd228,  14'd760,  14'd1368, 14'd2128 },
        '{14'd316,  14'd1053, 14'd1895, 14'd2947 },
        '{14'd422,  14'd1405, 14'd2529, 14'd3934 },
        '{14'd548,  14'd1828, 14'd3290, 14'd5117 },
        '{14'd696,  14'd2320, 14'd4176, 14'd6496 },
        '{14'd868,  14'd2893, 14'd5207, 14'd8099 },
        '{14'd1064, 14'd3548, 14'd6386, 14'd9933 },
        '{14'd1286, 14'd4288, 14'd7718, 14'd12005},
        '{14'd1536, 14'd5120, 14'd9216, 14'd14336}
    };

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/qoa_dequant_lut.sv
// Combinational dequantizer: scalefactor and 3-bit quantized residual to a signed 15-bit value.
module qoa_dequant_lut
    import qoa_pkg::*;
(
    input  logic        [SF_W-1:0] sf,
    input  logic        [QR_W-1:0] qr,
    output logic signed [DQ_W-1:0] value
);

    logic signed [DQ_W-1:0] mag;

    always_comb begin
        mag   = $signed({1'b0, DEQUANT_MAG[sf][qr[2:1]]});
        value = qr[0] ? -mag : mag;
    end

endmodule

// File: rtl/qoa_slice_dequant.sv
// Accepts one 64-bit QOA slice and streams its 20 dequantized residuals, one per handshake.
module qoa_slice_dequant
    import qoa_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int OUT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SLICE_W-1:0]            s_slice,
    input  logic [chan_w(CHANNELS)-1:0]   s_chan,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [OUT_W-1:0]              m_data,
    output logic [chan_w(CHANNELS)-1:0]   m_chan,
    output logic [4:0]                    m_index,
    output logic                          m_last
);

    state_t                  state;
    state_t                  state_next;
    logic [SF_W-1:0]         sf_q;
    logic [RES_BITS-1:0]     res_q;
    logic                    load;
    logic                    advance;
    logic                    out_fire;
    logic [SF_W-1:0]         lut_sf;
    logic [QR_W-1:0]         lut_qr;
    logic signed [DQ_W-1:0]  lut_value;

    assign out_fire = m_valid && m_ready;
    assign load     = s_valid && s_ready;
    assign advance  = out_fire && !m_last;

    // On load the LUT sees residual 0 straight from the input; otherwise the next queued residual.
    assign lut_sf = load ? s_slice[63:60] : sf_q;
    assign lut_qr = load ? s_slice[59:57] : res_q[RES_BITS-1 -: QR_W];

    qoa_dequant_lut u_lut (
        .sf    (lut_sf),
        .qr    (lut_qr),
        .value (lut_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load) state_next = EMIT;
            EMIT: if (out_fire && m_last && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state == EMIT);
        s_ready = (state == IDLE) || ((state == EMIT) && m_last && m_ready);
    end

    // res_q keeps the not-yet-presented residuals left-aligned, so the next one is always at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            sf_q    <= '0;
            res_q   <= '0;
            m_data  <= '0;
            m_chan  <= '0;
            m_index <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            sf_q    <= s_slice[63:60];
            res_q   <= {s_slice[56:0], 3'b000};
            m_data  <= OUT_W'(lut_value);
            m_chan  <= s_chan;
            m_index <= 5'd0;
            m_last  <= 1'b0;
        end else if (advance) begin
            res_q   <= {res_q[RES_BITS-QR_W-1:0], 3'b000};
            m_data  <= OUT_W'(lut_value);
            m_index <= m_index + 5'd1;
            m_last  <= (m_index == 5'd18);
        end
    end

endmodule

// File: tb/tb_qoa_slice_dequant.sv
// Directed self-checking bench for qoa_slice_dequant with CHANNELS=2, OUT_W=16.
module tb_qoa_slice_dequant;

    localparam int CHANNELS = 2;
    localparam int OUT_W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [63:0]       s_slice;
    logic [0:0]        s_chan;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic [0:0]        m_chan;
    logic [4:0]        m_index;
    logic              m_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qoa_slice_dequant #(
        .CHANNELS (CHANNELS),
        .OUT_W    (OUT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_slice (s_slice),
        .s_chan  (s_chan),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_chan  (m_chan),
        .m_index (m_index),
        .m_last  (m_last)
    );

    int mag_tab [16][4] = '{
        '{1, 3, 5, 7}, '{5, 18, 32, 49}, '{16, 53, 95, 147}, '{34, 113, 203, 315},
        '{63, 210, 378, 588}, '{104, 345, 621, 966}, '{158, 528, 950, 1477},
        '{228, 760, 1368, 2128}, '{316, 1053, 1895, 2947}, '{422, 1405, 2529, 3934},
        '{548, 1828, 3290, 5117}, '{696, 2320, 4176, 6496}, '{868, 2893, 5207, 8099},
        '{1064, 3548, 6386, 9933}, '{1286, 4288, 7718, 12005}, '{1536, 5120, 9216, 14336}
    };

    typedef struct {
        int sf;
        int qr;
        int expected;
    } vec_t;

    vec_t vecs [12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int exp_val(input int sf, input int qr);
        int m;
        m = mag_tab[sf][qr >> 1];
        return ((qr & 1) != 0) ? -m : m;
    endfunction

    function automatic logic [63:0] mk_slice(input int sf, input int q0, input int q1, input int fill);
        logic [63:0] s;
        int v;
        s = '0;
        s[63:60] = sf[3:0];
        for (int k = 0; k < 20; k++) begin
            v = (k == 0) ? q0 : ((k == 1) ? q1 : fill);
            s[59-3*k -: 3] = v[2:0];
        end
        return s;
    endfunction

    // Offer a slice and wait (bounded) for acceptance; returns showing beat 0.
    task automatic applyStimulus(input logic [63:0] slice, input logic chan);
        int n;
        s_slice = slice;
        s_chan  = chan;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            tick;
            n++;
        end
        if (!s_ready) checkOutput("accept_timeout", int'(s_ready), 1);
        tick;
        s_valid = 1'b0;
    endtask

    // Check all 20 beats of a slice, optionally stalling and offering the next slice early.
    task automatic drain(input logic [63:0] slice, input int chan, input int stall_at, input int stall_len,
                         input logic offer, input logic [63:0] next_slice, input int next_chan, input int offer_from);
        int sf;
        int qr;
        int ev;
        sf = int'(slice[63:60]);
        for (int k = 0; k < 20; k++) begin
            qr = int'(slice[59-3*k -: 3]);
            ev = exp_val(sf, qr);
            if (offer && k == offer_from) begin
                s_slice = next_slice;
                s_chan  = next_chan[0];
                s_valid = 1'b1;
            end
            if (k == stall_at) begin
                m_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    tick;
                    checkOutput("stall_valid", int'(m_valid), 1);
                    checkOutput("stall_index", int'(m_index), k);
                    checkOutput("stall_data", $signed(m_data), ev);
                end
                m_ready = 1'b1;
            end
            checkOutput("beat_valid", int'(m_valid), 1);
            checkOutput("beat_index", int'(m_index), k);
            checkOutput("beat_last", int'(m_last), int'(k == 19));
            checkOutput("beat_data", $signed(m_data), ev);
            checkOutput("beat_chan", int'(m_chan), chan);
            checkOutput("beat_s_ready", int'(s_ready), int'(k == 19));
            tick;
        end
        s_valid = 1'b0;
        if (!offer) checkOutput("after_idle", int'(m_valid), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_slice = '0;
        s_chan  = '0;
        m_ready = 1'b1;

        vecs[0]  = '{0, 0, 1};
        vecs[1]  = '{0, 1, -1};
        vecs[2]  = '{0, 7, -7};
        vecs[3]  = '{1, 2, 18};
        vecs[4]  = '{1, 3, -18};
        vecs[5]  = '{4, 4, 378};
        vecs[6]  = '{7, 6, 2128};
        vecs[7]  = '{10, 5, -3290};
        vecs[8]  = '{15, 6, 14336};
        vecs[9]  = '{15, 7, -14336};
        vecs[10] = '{13, 1, -1064};
        vecs[11] = '{9, 3, -1405};

        tick;
        tick;
        checkOutput("reset_m_valid", int'(m_valid), 0);
        checkOutput("reset_m_index", int'(m_index), 0);
        checkOutput("reset_m_last", int'(m_last), 0);
        checkOutput("reset_m_data", int'(m_data), 0);
        checkOutput("reset_m_chan", int'(m_chan), 0);
        rst = 1'b0;
        tick;
        checkOutput("ready_after_reset", int'(s_ready), 1);
        checkOutput("idle_m_valid", int'(m_valid), 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(mk_slice(vecs[i].sf, vecs[i].qr, 0, 0), 1'b0);
            checkOutput("vec_data", $signed(m_data), vecs[i].expected);
            checkOutput("vec_index", int'(m_index), 0);
            repeat (20) tick;
            checkOutput("vec_done", int'(m_valid), 0);
        end

        $display("[TB] all-zero slice");
        applyStimulus(64'h0, 1'b0);
        drain(64'h0, 0, -1, 0, 1'b0, 64'h0, 0, -1);

        $display("[TB] all-ones slice");
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(a, 1'b0);
        checkOutput("ones_raw", int'(m_data), 32'h0000_C800);
        drain(a, 0, -1, 0, 1'b0, 64'h0, 0, -1);

        $display("[TB] stall at beat 3");
        a = mk_slice(1, 2, 3, 0);
        applyStimulus(a, 1'b0);
        drain(a, 0, 3, 5, 1'b0, 64'h0, 0, -1);

        $display("[TB] back-to-back slices on two channels");
        a = mk_slice(2, 4, 4, 4);
        b = mk_slice(5, 3, 3, 3);
        applyStimulus(a, 1'b1);
        drain(a, 1, -1, 0, 1'b1, b, 0, 15);
        drain(b, 0, -1, 0, 1'b0, 64'h0, 0, -1);

        $display("[TB] reset mid-slice");
        a = mk_slice(3, 1, 5, 2);
        applyStimulus(a, 1'b1);
        repeat (10) tick;
        checkOutput("pre_reset_index", int'(m_index), 10);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("post_reset_m_valid", int'(m_valid), 0);
        checkOutput("post_reset_s_ready", int'(s_ready), 1);
        checkOutput("post_reset_m_index", int'(m_index), 0);
        checkOutput("post_reset_m_chan", int'(m_chan), 0);
        b = mk_slice(6, 7, 0, 6);
        applyStimulus(b, 1'b0);
        drain(b, 0, -1, 0, 1'b0, 64'h0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
